// File: rtl/mips_mem_pkg.sv
// ----------------------------------------------------------------------------
// mips_mem_pkg: size and state encodings shared by the store-narrowing path.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mips_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Reserved size is rejected just like a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a_lo);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a_lo[0];
      SZ_WORD: return (a_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_merge.sv
// ----------------------------------------------------------------------------
// byte_merge: replaces the addressed byte/half lane(s) of a word, or the whole word.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module byte_merge
  import mips_mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] old_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_sel_i,
  output logic [31:0] merged_o
);

  logic [1:0] byte_lane;
  logic       half_lane;

  assign byte_lane = BIG_ENDIAN ? (2'd3 - lane_sel_i) : lane_sel_i;
  assign half_lane = lane_sel_i[1] ^ BIG_ENDIAN;

  always_comb begin
    merged_o = old_i;
    case (size_i)
      SZ_BYTE: merged_o[{byte_lane, 3'b000} +: 8]  = data_i[7:0];
      SZ_HALF: merged_o[{half_lane, 4'b0000} +: 16] = data_i[15:0];
      SZ_WORD: merged_o = data_i;
      default: merged_o = old_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/store_narrow_unit.sv
// ----------------------------------------------------------------------------
// store_narrow_unit: sb/sh/sw sequencer doing read-modify-write for narrow stores.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module store_narrow_unit
  import mips_mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic [29:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr,
  output logic [31:0] mem_wdata
);

  state_e      state_q;
  size_e       size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic        done_q;
  logic        misalign_q;
  logic [31:0] merged_word;

  byte_merge #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_byte_merge (
    .old_i      (word_q),
    .data_i     (wdata_q),
    .size_i     (size_q),
    .lane_sel_i (addr_q[1:0]),
    .merged_o   (merged_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      size_q     <= SZ_BYTE;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            size_q  <= size_e'(size);
            addr_q  <= addr;
            wdata_q <= wdata;
            if (is_misaligned(size, addr[1:0])) begin
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
            end else if (size == SZ_WORD) begin
              state_q  <= ST_WRITE;
              mem_wr_q <= 1'b1;
            end else begin
              state_q  <= ST_READ;
              mem_rd_q <= 1'b1;
            end
          end
        end
        ST_READ:  state_q <= ST_MERGE;
        // Read data arrives one cycle after the strobe, i.e. during MERGE.
        ST_MERGE: begin
          word_q   <= mem_rdata;
          state_q  <= ST_WRITE;
          mem_wr_q <= 1'b1;
        end
        ST_WRITE: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign misalign  = misalign_q;
  assign mem_addr  = addr_q[31:2];
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wr_q ? merged_word : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_store_narrow_unit.sv
// ----------------------------------------------------------------------------
// tb_store_narrow_unit: directed bench for both byte orders of store_narrow_unit.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_store_narrow_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;

  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  misalign;
  logic [1:0]  mem_rd;
  logic [1:0]  mem_wr;
  logic [29:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];

  int passes = 0;
  int total  = 0;
  int rd_cnt [2] = '{0, 0};
  int wr_cnt [2] = '{0, 0};
  int both_cnt = 0;

  store_narrow_unit #(.BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy[0]), .done(done[0]), .misalign(misalign[0]), .mem_addr(mem_addr[0]),
    .mem_rd(mem_rd[0]), .mem_rdata(mem_rdata), .mem_wr(mem_wr[0]), .mem_wdata(mem_wdata[0])
  );

  store_narrow_unit #(.BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy[1]), .done(done[1]), .misalign(misalign[1]), .mem_addr(mem_addr[1]),
    .mem_rd(mem_rd[1]), .mem_rdata(mem_rdata), .mem_wr(mem_wr[1]), .mem_wdata(mem_wdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_rd[d]) rd_cnt[d]++;
      if (mem_wr[d]) wr_cnt[d]++;
      if (mem_rd[d] && mem_wr[d]) both_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic word_store(input int d, input logic [31:0] a, input logic [31:0] wd, input string tag);
    int rd0 = rd_cnt[d];
    int wr0 = wr_cnt[d];
    size = 2'b10; addr = a; wdata = wd; req[d] = 1'b1;
    tick();
    req[d] = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0; size = 2'b00;
    chk({tag, "_wr"},    32'(mem_wr[d]), 32'd1);
    chk({tag, "_busy"},  32'(busy[d]), 32'd1);
    chk({tag, "_addr"},  {2'b00, mem_addr[d]}, {2'b00, a[31:2]});
    chk({tag, "_wdata"}, mem_wdata[d], wd);
    tick();
    chk({tag, "_done"},  {30'd0, done[d], misalign[d]}, 32'd2);
    chk({tag, "_wd0"},   mem_wdata[d], 32'h0);
    tick();
    chk({tag, "_idle"},  32'(busy[d]), 32'd0);
    chk({tag, "_rdcnt"}, rd_cnt[d] - rd0, 32'd0);
    chk({tag, "_wrcnt"}, wr_cnt[d] - wr0, 32'd1);
  endtask

  task automatic narrow_store(input int d, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input logic [31:0] expw, input string tag);
    int rd0 = rd_cnt[d];
    int wr0 = wr_cnt[d];
    size = sz; addr = a; wdata = wd; mem_rdata = 32'hA5A5_A5A5; req[d] = 1'b1;
    tick();
    req[d] = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF; size = 2'b10;
    chk({tag, "_rd"},    {30'd0, mem_rd[d], mem_wr[d]}, 32'd2);
    tick();
    mem_rdata = rd;
    chk({tag, "_merge"}, {30'd0, mem_rd[d], mem_wr[d]}, 32'd0);
    tick();
    mem_rdata = 32'hA5A5_A5A5;
    chk({tag, "_wr"},    32'(mem_wr[d]), 32'd1);
    chk({tag, "_addr"},  {2'b00, mem_addr[d]}, {2'b00, a[31:2]});
    chk({tag, "_wdata"}, mem_wdata[d], expw);
    tick();
    chk({tag, "_done"},  {30'd0, done[d], misalign[d]}, 32'd2);
    chk({tag, "_wd0"},   mem_wdata[d], 32'h0);
    tick();
    chk({tag, "_idle"},  32'(busy[d]), 32'd0);
    chk({tag, "_rdcnt"}, rd_cnt[d] - rd0, 32'd1);
    chk({tag, "_wrcnt"}, wr_cnt[d] - wr0, 32'd1);
  endtask

  task automatic reject(input int d, input logic [1:0] sz, input logic [31:0] a, input string tag);
    int rd0 = rd_cnt[d];
    int wr0 = wr_cnt[d];
    size = sz; addr = a; wdata = 32'h1234_5678; req[d] = 1'b1;
    tick();
    req[d] = 1'b0;
    chk({tag, "_donemis"}, {30'd0, done[d], misalign[d]}, 32'd3);
    chk({tag, "_busy"},    32'(busy[d]), 32'd1);
    tick();
    chk({tag, "_after"},   {29'd0, busy[d], done[d], misalign[d]}, 32'd0);
    chk({tag, "_rdwr"},    (rd_cnt[d] - rd0) + (wr_cnt[d] - wr0), 32'd0);
  endtask

  initial begin
    int wr0;
    rst_n = 1'b0; req = 2'b01; size = 2'b10; addr = 32'h10; wdata = 32'h0; mem_rdata = 32'h0;
    tick();
    tick();
    // req held high under reset must not be accepted
    chk("rst_busy",   32'(busy[0]), 32'd0);
    chk("rst_flags",  {27'd0, done[0], misalign[0], mem_rd[0], mem_wr[0], busy[1]}, 32'd0);
    chk("rst_addr",   {2'b00, mem_addr[0]}, 32'd0);
    chk("rst_wdata",  mem_wdata[0], 32'd0);
    req = 2'b00;

    // First edge with rst_n=1 accepts the word store
    rst_n = 1'b1;
    word_store(0, 32'h0000_0010, 32'hDEAD_BEEF, "sw");

    narrow_store(0, 2'b00, 32'h0000_0013, 32'h0000_00AB, 32'h1122_3344, 32'hAB22_3344, "sb_le");
    narrow_store(1, 2'b01, 32'h0000_0022, 32'h0000_CAFE, 32'h1122_3344, 32'h1122_CAFE, "sh_be");
    narrow_store(0, 2'b01, 32'h0000_0022, 32'h0000_CAFE, 32'h1122_3344, 32'hCAFE_3344, "sh_le");
    narrow_store(1, 2'b00, 32'h0000_0013, 32'hFFFF_FFAB, 32'h1122_3344, 32'h1122_33AB, "sb_be");
    narrow_store(0, 2'b00, 32'h0000_0101, 32'h0000_005A, 32'hFFFF_FFFF, 32'hFFFF_5AFF, "sb_le1");

    reject(0, 2'b01, 32'h0000_0001, "sh_mis");
    reject(0, 2'b11, 32'h0000_0000, "sz_rsvd");
    reject(1, 2'b10, 32'h0000_0006, "sw_mis");

    // Reset sampled while in MERGE aborts the store
    wr0 = wr_cnt[0];
    size = 2'b00; addr = 32'h0000_0013; wdata = 32'hAB; req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    rst_n = 1'b0;
    mem_rdata = 32'h1122_3344;
    tick();
    rst_n = 1'b1;
    chk("abort_flags", {27'd0, busy[0], done[0], misalign[0], mem_rd[0], mem_wr[0]}, 32'd0);
    chk("abort_addr",  {2'b00, mem_addr[0]}, 32'd0);
    chk("abort_wdata", mem_wdata[0], 32'd0);
    tick();
    tick();
    chk("abort_nowr",  wr_cnt[0] - wr0, 32'd0);

    // req held across two back-to-back word stores
    wr0 = wr_cnt[0];
    size = 2'b10; addr = 32'h0000_0040; wdata = 32'h1234_5678; req = 2'b01;
    tick();
    chk("b2b_wr1",    mem_wdata[0], 32'h1234_5678);
    tick();
    chk("b2b_done1",  32'(done[0]), 32'd1);
    tick();
    chk("b2b_gap",    {30'd0, busy[0], mem_wr[0]}, 32'd0);
    addr = 32'h0000_0044; wdata = 32'h9ABC_DEF0;
    tick();
    req = 2'b00;
    chk("b2b_wr2",    mem_wdata[0], 32'h9ABC_DEF0);
    chk("b2b_addr2",  {2'b00, mem_addr[0]}, 32'h0000_0011);
    tick();
    chk("b2b_done2",  32'(done[0]), 32'd1);
    tick();
    chk("b2b_wrcnt",  wr_cnt[0] - wr0, 32'd2);

    chk("rd_wr_overlap", both_cnt, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_narrow_unit.md
STORE_NARROW_UNIT -- requirements
Module: store_narrow_unit

Interface
REQ-001 The block SHALL have parameter BIG_ENDIAN, default 0: 0 = little-endian byte lanes; 1 = big-endian byte lanes.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port req, input, 1 bit: store request, sampled only in IDLE.
REQ-005 The block SHALL have port size, input, 2 bits: 00 = byte (sb), 01 = half (sh), 10 = word (sw), 11 = reserved.
REQ-006 The block SHALL have port addr, input, 32 bits: byte address of the store.
REQ-007 The block SHALL have port wdata, input, 32 bits: register value; only the low 8 or 16 bits are used for byte or half stores.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port misalign, output, 1 bit: high only together with done, for a rejected request.
REQ-011 The block SHALL have port mem_addr, output, 30 bits: word address, equal to latched addr[31:2].
REQ-012 The block SHALL have port mem_rd, output, 1 bit: word read strobe.
REQ-013 The block SHALL have port mem_rdata, input, 32 bits: read word, valid exactly one cycle after mem_rd.
REQ-014 The block SHALL have port mem_wr, output, 1 bit: word write strobe.
REQ-015 The block SHALL have port mem_wdata, output, 32 bits: merged word to write.

Function
REQ-016 States SHALL be IDLE, READ, MERGE, WRITE and DONE; the state register SHALL be the only sequencing state.
REQ-017 In IDLE with req=1, the block SHALL latch size, addr and wdata. Those latched values SHALL be used for the whole operation; input changes afterwards SHALL have no effect.
REQ-018 An accepted request SHALL be rejected when size=11, when size=01 with addr[0]=1, or when size=10 with addr[1:0]≠00.
REQ-019 A rejected request SHALL go IDLE→DONE, with done=1 and misalign=1 in the DONE cycle, and mem_rd=mem_wr=0 throughout.
REQ-020 A word store (acceptance at edge N) SHALL go IDLE→WRITE→DONE: mem_wr=1 and mem_wdata=wdata in cycle N+1; done in cycle N+2.
REQ-021 A byte or half store SHALL go IDLE→READ→MERGE→WRITE→DONE:
- READ (N+1): mem_rd=1;
- MERGE (N+2): capture mem_rdata into an internal word register;
- WRITE (N+3): mem_wr=1, mem_wdata = merged word;
- DONE (N+4): done pulses.
REQ-022 Merge rule: replace only the target lane(s) of the captured word; every other bit SHALL be preserved bit-exact.
REQ-023 Byte lane with BIG_ENDIAN=0 SHALL be addr[1:0] (lane k = bits 8k+7..8k); with BIG_ENDIAN=1 it SHALL be 3−addr[1:0].
REQ-024 Half lane SHALL be addr[1] (or its inverse when BIG_ENDIAN=1).
REQ-025 DONE SHALL always return to IDLE after one cycle. req in DONE SHALL be ignored; a new request is accepted no earlier than the following IDLE cycle.
REQ-026 req while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-027 mem_rd and mem_wr SHALL never be high in the same cycle; each SHALL be high for at most one cycle per request.
REQ-028 mem_addr SHALL hold its value from acceptance through DONE.
REQ-029 mem_wdata SHALL be 0 whenever mem_wr=0.
REQ-030 misalign SHALL be 0 whenever done=0.

Reset
REQ-031 When rst_n=0 at a clock edge, the block SHALL enter IDLE regardless of current state and abort any operation in progress; no mem_wr SHALL occur after reset is sampled.
REQ-032 Reset values SHALL be: busy=0, done=0, misalign=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, internal word register=0.
REQ-033 req SHALL be ignored while rst_n=0; the first acceptance SHALL be possible at the first edge where rst_n=1.

Structure
REQ-034 A shared package/header mips_mem_pkg SHALL hold:
- size encodings SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10;
- state encodings for IDLE, READ, MERGE, WRITE, DONE.
REQ-035 Lane replacement SHALL be one combinational sub-module, byte_merge (inputs: old word, data, size, lane select, BIG_ENDIAN; output: merged word).
REQ-036 The FSM, latches and strobe logic SHALL reside in store_narrow_unit.

Verification
REQ-037 Bench SHALL cover: sw, addr=0x00000010, wdata=0xDEADBEEF → mem_wr in cycle N+1 with mem_addr=0x4 and mem_wdata=0xDEADBEEF; done in N+2; misalign=0; mem_rd never high.
REQ-038 Bench SHALL cover: sb, addr=0x00000013, wdata=0x000000AB, mem_rdata=0x11223344, BIG_ENDIAN=0 → mem_wdata=0xAB223344 in N+3; done in N+4.
REQ-039 Bench SHALL cover: sh, addr=0x00000022, wdata=0x0000CAFE, mem_rdata=0x11223344, BIG_ENDIAN=1 → mem_wdata=0x1122CAFE.
REQ-040 Bench SHALL cover: sh with addr=0x00000001, and separately size=11 → done=misalign=1 in N+1; mem_rd=mem_wr=0 throughout.
REQ-041 Bench SHALL cover: sb accepted, rst_n=0 sampled in MERGE → IDLE next cycle; all outputs zero; no mem_wr pulse.
REQ-042 Bench SHALL cover: req held high continuously across two back-to-back sw → second acceptance occurs in the IDLE cycle after DONE; exactly one mem_wr per request.
